// File: rtl/forward_arb_mux.sv
// Round-robin arbiter and 64-bit AXI-Stream mux for up to four forward_pkt_module sources.
// A granted source owns the output for a whole session; beats pass through a two-entry skid stage.
module forward_arb_mux #(
  parameter int unsigned P_PORTS   = 4,
  parameter int unsigned P_TIMEOUT = 1024
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [P_PORTS-1:0]      i_forward_req,
  output logic [P_PORTS-1:0]      o_forward_resp,
  input  logic [P_PORTS-1:0]      i_forward_finish,
  input  logic [P_PORTS-1:0]      s_axis_tvalid,
  input  logic [64*P_PORTS-1:0]   s_axis_tdata,
  input  logic [P_PORTS-1:0]      s_axis_tlast,
  input  logic [8*P_PORTS-1:0]    s_axis_tkeep,
  output logic [P_PORTS-1:0]      s_axis_tready,
  output logic                    m_axis_tvalid,
  output logic [63:0]             m_axis_tdata,
  output logic                    m_axis_tlast,
  output logic [7:0]              m_axis_tkeep,
  output logic                    m_axis_tuser,
  input  logic                    m_axis_tready,
  output logic [1:0]              o_grant_idx,
  output logic                    o_busy
);

  typedef enum logic [1:0] {IDLE, GRANT, XFER} state_t;

  localparam logic [1:0]  LAST_RST = 2'(P_PORTS - 1);
  localparam logic [15:0] TIMEOUT  = 16'(P_TIMEOUT);

  state_t              state;
  logic [1:0]          w;
  logic [1:0]          last;
  logic                in_pkt;
  logic [15:0]         idle_cnt;

  logic [1:0]          win;
  logic [P_PORTS-1:0]  win_oh;
  logic                found;

  logic                sel_valid;
  logic [63:0]         sel_data;
  logic                sel_last;
  logic [7:0]          sel_keep;
  logic                sel_finish;
  logic                accept;

  logic [1:0]          sk_cnt;
  logic                skid_full;
  logic [63:0]         h_data, t_data;
  logic [7:0]          h_keep, t_keep;
  logic                h_last, t_last;
  logic                pop;

  // First requester at offset 1..P_PORTS from the previous owner wins.
  always_comb begin
    win    = last;
    win_oh = '0;
    found  = 1'b0;
    for (int unsigned i = 1; i <= P_PORTS; i++) begin
      for (int unsigned k = 0; k < P_PORTS; k++) begin
        if (!found && i_forward_req[k] && (k == (32'(last) + i) % P_PORTS)) begin
          found     = 1'b1;
          win       = 2'(k);
          win_oh[k] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_valid     = 1'b0;
    sel_data      = '0;
    sel_last      = 1'b0;
    sel_keep      = '0;
    sel_finish    = 1'b0;
    s_axis_tready = '0;
    for (int unsigned k = 0; k < P_PORTS; k++) begin
      if (w == 2'(k)) begin
        sel_valid        = s_axis_tvalid[k];
        sel_data         = s_axis_tdata[64*k +: 64];
        sel_last         = s_axis_tlast[k];
        sel_keep         = s_axis_tkeep[8*k +: 8];
        sel_finish       = i_forward_finish[k];
        s_axis_tready[k] = (state == XFER) && !skid_full;
      end
    end
  end

  assign accept = (state == XFER) && sel_valid && !skid_full;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state          <= IDLE;
      w              <= '0;
      last           <= LAST_RST;
      in_pkt         <= 1'b0;
      idle_cnt       <= '0;
      o_forward_resp <= '0;
      o_busy         <= 1'b0;
    end else begin
      o_forward_resp <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            state          <= GRANT;
            w              <= win;
            o_forward_resp <= win_oh;
            o_busy         <= 1'b1;
          end
        end
        GRANT: begin
          state    <= XFER;
          idle_cnt <= '0;
        end
        XFER: begin
          if (accept) begin
            idle_cnt <= '0;
            in_pkt   <= !sel_last;
            if (sel_last && sel_finish) begin
              state  <= IDLE;
              o_busy <= 1'b0;
              last   <= w;
            end
          end else if (!in_pkt && (idle_cnt >= TIMEOUT)) begin
            state  <= IDLE;
            o_busy <= 1'b0;
            last   <= w;
          end else if (idle_cnt != '1) begin
            idle_cnt <= idle_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_grant_idx = w;

  // Head entry drives the output; the tail only holds a beat while the head is stalled.
  assign skid_full = (sk_cnt == 2'd2);
  assign pop       = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      sk_cnt <= '0;
      h_data <= '0;
      h_keep <= '0;
      h_last <= 1'b0;
      t_data <= '0;
      t_keep <= '0;
      t_last <= 1'b0;
    end else begin
      case ({accept, pop})
        2'b10: begin
          if (sk_cnt == 2'd0) begin
            h_data <= sel_data;
            h_keep <= sel_keep;
            h_last <= sel_last;
          end else begin
            t_data <= sel_data;
            t_keep <= sel_keep;
            t_last <= sel_last;
          end
          sk_cnt <= sk_cnt + 2'd1;
        end
        2'b01: begin
          h_data <= t_data;
          h_keep <= t_keep;
          h_last <= t_last;
          sk_cnt <= sk_cnt - 2'd1;
        end
        2'b11: begin
          if (sk_cnt == 2'd1) begin
            h_data <= sel_data;
            h_keep <= sel_keep;
            h_last <= sel_last;
          end else begin
            h_data <= t_data;
            h_keep <= t_keep;
            h_last <= t_last;
            t_data <= sel_data;
            t_keep <= sel_keep;
            t_last <= sel_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_axis_tvalid = (sk_cnt != 2'd0);
  assign m_axis_tdata  = h_data;
  assign m_axis_tkeep  = h_keep;
  assign m_axis_tlast  = h_last;
  assign m_axis_tuser  = 1'b0;

endmodule

// File: tb/tb_forward_arb_mux.sv
// Directed bench for forward_arb_mux: arbitration table plus hand-written session,
// backpressure, timeout and reset sequences, with an in-order output scoreboard.
module tb_forward_arb_mux;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic [3:0]   i_forward_req;
  logic [3:0]   o_forward_resp;
  logic [3:0]   i_forward_finish;
  logic [3:0]   s_axis_tvalid;
  logic [255:0] s_axis_tdata;
  logic [3:0]   s_axis_tlast;
  logic [31:0]  s_axis_tkeep;
  logic [3:0]   s_axis_tready;
  logic         m_axis_tvalid;
  logic [63:0]  m_axis_tdata;
  logic         m_axis_tlast;
  logic [7:0]   m_axis_tkeep;
  logic         m_axis_tuser;
  logic         m_axis_tready;
  logic [1:0]   o_grant_idx;
  logic         o_busy;

  logic         sv [4];
  logic [63:0]  sd [4];
  logic         sl [4];
  logic [7:0]   sk [4];
  logic         sf [4];

  forward_arb_mux #(.P_PORTS(4), .P_TIMEOUT(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_forward_req(i_forward_req), .o_forward_resp(o_forward_resp),
    .i_forward_finish(i_forward_finish),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
    .s_axis_tlast(s_axis_tlast), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tready(s_axis_tready),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
    .o_grant_idx(o_grant_idx), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  always_comb begin
    s_axis_tvalid    = '0;
    s_axis_tdata     = '0;
    s_axis_tlast     = '0;
    s_axis_tkeep     = '0;
    i_forward_finish = '0;
    for (int k = 0; k < 4; k++) begin
      s_axis_tvalid[k]       = sv[k];
      s_axis_tdata[64*k+:64] = sd[k];
      s_axis_tlast[k]        = sl[k];
      s_axis_tkeep[8*k+:8]   = sk[k];
      i_forward_finish[k]    = sf[k];
    end
  end

  // Output capture and grant-pulse counting, sampled mid-cycle.
  logic [63:0] got_data [512];
  logic        got_last [512];
  logic [7:0]  got_keep [512];
  int          got_n    = 0;
  int          resp_cnt = 0;

  always @(negedge i_clk) begin
    if (i_rst && m_axis_tvalid && m_axis_tready && got_n < 512) begin
      got_data[got_n] = m_axis_tdata;
      got_last[got_n] = m_axis_tlast;
      got_keep[got_n] = m_axis_tkeep;
      got_n++;
    end
    if (|o_forward_resp) resp_cnt++;
  end

  logic [63:0] exp_data [512];
  logic        exp_last [512];
  logic [7:0]  exp_keep [512];
  int          exp_n = 0;
  int          rd    = 0;
  int          n_tests = 0;
  int          n_fail  = 0;

  typedef struct {
    logic [3:0] req;
    int         idx;
    int         nb;
  } arb_vec_t;

  arb_vec_t tbl [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_grant(output int cyc, output logic [3:0] r);
    cyc = 0;
    r   = '0;
    while (r == 4'd0 && cyc < 100) begin
      @(negedge i_clk);
      cyc++;
      r = o_forward_resp;
    end
    chk("grant_seen", 64'(|r), 64'd1);
    @(posedge i_clk); #1;
  endtask

  task automatic send_beat(input int p, input logic [63:0] d, input logic l,
                           input logic [7:0] k, input logic f, output int waits);
    logic ok;
    ok    = 1'b0;
    waits = 0;
    sv[p] = 1'b1; sd[p] = d; sl[p] = l; sk[p] = k; sf[p] = f;
    while (!ok && waits < 200) begin
      @(negedge i_clk);
      waits++;
      if (s_axis_tready[p]) ok = 1'b1;
      @(posedge i_clk); #1;
    end
    chk("beat_accepted", 64'(ok), 64'd1);
    if (ok) begin
      exp_data[exp_n] = d;
      exp_last[exp_n] = l;
      exp_keep[exp_n] = k;
      exp_n++;
    end
    sv[p] = 1'b0; sl[p] = 1'b0; sf[p] = 1'b0;
  endtask

  task automatic check_stream(input string name);
    int t;
    t = 0;
    while (got_n < exp_n && t < 300) begin
      @(negedge i_clk);
      t++;
    end
    repeat (3) @(negedge i_clk);
    chk({name, "_beat_count"}, 64'(got_n), 64'(exp_n));
    for (int i = rd; i < exp_n && i < got_n; i++) begin
      chk({name, "_data"}, got_data[i], exp_data[i]);
      chk({name, "_last_keep"}, 64'({got_last[i], got_keep[i]}), 64'({exp_last[i], exp_keep[i]}));
    end
    rd    = got_n;
    exp_n = got_n;
    @(posedge i_clk); #1;
  endtask

  initial begin
    int          cyc;
    int          wt;
    int          c0;
    logic [3:0]  r;
    logic        any_rdy;
    logic [63:0] d;

    tbl[0] = '{4'b1011, 0, 2};
    tbl[1] = '{4'b1011, 1, 2};
    tbl[2] = '{4'b1011, 3, 2};
    tbl[3] = '{4'b1011, 0, 2};
    tbl[4] = '{4'b0100, 2, 1};
    tbl[5] = '{4'b0011, 0, 2};
    tbl[6] = '{4'b1000, 3, 3};
    tbl[7] = '{4'b0110, 1, 2};
    tbl[8] = '{4'b0101, 2, 2};

    for (int k = 0; k < 4; k++) begin
      sv[k] = 1'b0; sd[k] = '0; sl[k] = 1'b0; sk[k] = '0; sf[k] = 1'b0;
    end
    i_forward_req = '0;
    m_axis_tready = 1'b1;
    i_rst         = 1'b0;

    // Reset values
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_resp",   64'(o_forward_resp), 64'd0);
    chk("rst_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_mvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_mdata",  m_axis_tdata, 64'd0);
    chk("rst_mlast_keep_user", 64'({m_axis_tlast, m_axis_tkeep, m_axis_tuser}), 64'd0);
    chk("rst_busy_idx", 64'({o_busy, o_grant_idx}), 64'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;

    // Arbitration table: sessions back to back
    for (int t = 0; t < 9; t++) begin
      c0 = resp_cnt;
      i_forward_req = tbl[t].req;
      wait_grant(cyc, r);
      i_forward_req = '0;
      chk("rr_resp", 64'(r), 64'(4'(1) << tbl[t].idx));
      chk("rr_idx", 64'(o_grant_idx), 64'(tbl[t].idx));
      if (t > 0) chk("rr_gap", 64'(cyc), 64'd2);
      for (int b = 0; b < tbl[t].nb; b++) begin
        d = 64'hA000_0000_0000_0000 + 64'(t * 16 + b);
        send_beat(tbl[t].idx, d, b == tbl[t].nb - 1, 8'hFF, b == tbl[t].nb - 1, wt);
      end
      chk("rr_pulse_count", 64'(resp_cnt - c0), 64'd1);
    end
    check_stream("rr");

    // Single source, 4-beat packet
    c0 = resp_cnt;
    i_forward_req = 4'b0100;
    wait_grant(cyc, r);
    i_forward_req = '0;
    chk("ss_resp", 64'(r), 64'b0100);
    chk("ss_busy_on", 64'(o_busy), 64'd1);
    send_beat(2, 64'h5500_0000_0000_0000, 1'b0, 8'hFF, 1'b0, wt);
    @(negedge i_clk);
    chk("ss_latency_valid", 64'(m_axis_tvalid), 64'd1);
    chk("ss_latency_data", m_axis_tdata, 64'h5500_0000_0000_0000);
    @(posedge i_clk); #1;
    send_beat(2, 64'h5500_0000_0000_0001, 1'b0, 8'hFF, 1'b0, wt);
    send_beat(2, 64'h5500_0000_0000_0002, 1'b0, 8'hFF, 1'b0, wt);
    chk("ss_busy_mid", 64'(o_busy), 64'd1);
    send_beat(2, 64'h5500_0000_0000_0003, 1'b1, 8'h0F, 1'b1, wt);
    @(negedge i_clk);
    chk("ss_busy_off", 64'(o_busy), 64'd0);
    chk("ss_pulse_count", 64'(resp_cnt - c0), 64'd1);
    @(posedge i_clk); #1;
    check_stream("ss");

    // Multi-packet session on port 1 while port 0 waits
    i_forward_req = 4'b0010;
    wait_grant(cyc, r);
    chk("mp_resp", 64'(r), 64'b0010);
    i_forward_req = 4'b0011;
    c0 = resp_cnt;
    for (int pk = 0; pk < 3; pk++) begin
      send_beat(1, 64'h6600_0000_0000_0000 + 64'(pk * 16), 1'b0, 8'hFF, 1'b0, wt);
      send_beat(1, 64'h6600_0000_0000_0001 + 64'(pk * 16), 1'b1, 8'h3F, pk == 2, wt);
      if (pk < 2) begin
        @(negedge i_clk);
        chk("mp_busy_hold", 64'({o_busy, o_grant_idx}), 64'({1'b1, 2'd1}));
        @(posedge i_clk); #1;
      end
    end
    wait_grant(cyc, r);
    chk("mp_next_resp", 64'(r), 64'b0001);
    chk("mp_next_gap", 64'(cyc), 64'd2);
    chk("mp_no_early_grant", 64'(resp_cnt - c0), 64'd1);
    i_forward_req = '0;
    send_beat(0, 64'h6600_0000_0000_00FF, 1'b1, 8'hFF, 1'b1, wt);
    check_stream("mp");

    // Backpressure: 8-beat packet with downstream stalled 10 cycles
    i_forward_req = 4'b1000;
    wait_grant(cyc, r);
    i_forward_req = '0;
    chk("bp_resp", 64'(r), 64'b1000);
    m_axis_tready = 1'b0;
    send_beat(3, 64'h7700_0000_0000_0000, 1'b0, 8'hFF, 1'b0, wt);
    send_beat(3, 64'h7700_0000_0000_0001, 1'b0, 8'hFF, 1'b0, wt);
    sv[3] = 1'b1; sd[3] = 64'h7700_0000_0000_0002; sl[3] = 1'b0; sk[3] = 8'hFF; sf[3] = 1'b0;
    any_rdy = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge i_clk);
      any_rdy = any_rdy | s_axis_tready[3];
    end
    chk("bp_tready_low", 64'(any_rdy), 64'd0);
    chk("bp_head_valid", 64'(m_axis_tvalid), 64'd1);
    chk("bp_head_data", m_axis_tdata, 64'h7700_0000_0000_0000);
    @(posedge i_clk); #1;
    m_axis_tready = 1'b1;
    send_beat(3, 64'h7700_0000_0000_0002, 1'b0, 8'hFF, 1'b0, wt);
    chk("bp_reready_delay", 64'(wt), 64'd2);
    for (int b = 3; b < 8; b++)
      send_beat(3, 64'h7700_0000_0000_0000 + 64'(b), b == 7, 8'hFF, b == 7, wt);
    check_stream("bp");

    // Timeout between packets releases; silence mid-packet does not
    i_forward_req = 4'b0001;
    wait_grant(cyc, r);
    i_forward_req = '0;
    chk("to_resp", 64'(r), 64'b0001);
    send_beat(0, 64'h8800_0000_0000_0000, 1'b0, 8'hFF, 1'b0, wt);
    send_beat(0, 64'h8800_0000_0000_0001, 1'b1, 8'hFF, 1'b0, wt);
    repeat (16) @(negedge i_clk);
    chk("to_busy_before", 64'(o_busy), 64'd1);
    repeat (2) @(negedge i_clk);
    chk("to_released", 64'(o_busy), 64'd0);
    @(posedge i_clk); #1;
    i_forward_req = 4'b0001;
    wait_grant(cyc, r);
    i_forward_req = '0;
    chk("tm_resp", 64'(r), 64'b0001);
    send_beat(0, 64'h8800_0000_0000_0010, 1'b0, 8'hFF, 1'b0, wt);
    repeat (40) @(negedge i_clk);
    chk("tm_no_release", 64'(o_busy), 64'd1);
    @(posedge i_clk); #1;
    send_beat(0, 64'h8800_0000_0000_0011, 1'b1, 8'hFF, 1'b1, wt);
    @(negedge i_clk);
    chk("tm_end", 64'(o_busy), 64'd0);
    @(posedge i_clk); #1;
    check_stream("to");

    // Reset pulse mid-packet with a beat held in the skid
    i_forward_req = 4'b0100;
    wait_grant(cyc, r);
    i_forward_req = '0;
    chk("rm_resp", 64'(r), 64'b0100);
    m_axis_tready = 1'b0;
    send_beat(2, 64'h9900_0000_0000_0000, 1'b0, 8'hFF, 1'b0, wt);
    sv[2] = 1'b1; sd[2] = 64'h9900_0000_0000_0001; sk[2] = 8'hFF;
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("rm_pre_valid", 64'(m_axis_tvalid), 64'd1);
    @(negedge i_clk);
    chk("rm_mvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rm_mdata", m_axis_tdata, 64'd0);
    chk("rm_keep_last", 64'({m_axis_tlast, m_axis_tkeep}), 64'd0);
    chk("rm_busy_idx", 64'({o_busy, o_grant_idx}), 64'd0);
    chk("rm_tready_resp", 64'({s_axis_tready, o_forward_resp}), 64'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    sv[2] = 1'b0;
    m_axis_tready = 1'b1;
    rd    = got_n;
    exp_n = got_n;
    i_forward_req = 4'b1011;
    wait_grant(cyc, r);
    i_forward_req = '0;
    chk("rm_restart_resp", 64'(r), 64'b0001);
    chk("rm_restart_idx", 64'(o_grant_idx), 64'd0);
    send_beat(0, 64'h9900_0000_0000_00AA, 1'b1, 8'h01, 1'b1, wt);
    check_stream("rm");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
